// File: rtl/conv_stream_pkg.sv
//------------------------------------------------------------------------------
// conv_stream_pkg : shared sizes, state encoding and data types for the
//                   convolution engine stream driver.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conv_stream_pkg;

  localparam int FILT_LEN  = 10;
  localparam int IMG_LEN   = 64;
  localparam int RES_LEN   = 16;
  localparam int BUF_DEPTH = FILT_LEN + IMG_LEN;
  localparam int TIMEOUT   = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_FILT = 3'd1,
    S_SEND_IMG  = 3'd2,
    S_WAIT      = 3'd3,
    S_COLLECT   = 3'd4
  } state_e;

  typedef logic signed [3:0]  nibble_t;
  typedef logic signed [15:0] result_t;

endpackage

`default_nettype wire

// File: rtl/conv_result_buf.sv
//------------------------------------------------------------------------------
// conv_result_buf : 16 x 16-bit result register file, one capture write port
//                   and a combinational read port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_result_buf
  import conv_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  result_t     wdata_i,
  input  logic [3:0]  raddr_i,
  output result_t     rdata_o
);

  result_t mem_q [RES_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RES_LEN; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/conv_stream_driver.sv
//------------------------------------------------------------------------------
// conv_stream_driver : streams preloaded filter taps and image pixels to the
//                      convolution engine and collects its 16 results.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_stream_driver
  import conv_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        filter_valid,
  output logic        image_valid,
  output logic [3:0]  in_data,
  input  logic        out_valid,
  input  logic [15:0] out_data,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam logic [6:0] c_LAST_IDX = 7'(BUF_DEPTH - 1);
  localparam logic [6:0] c_FILT_END = 7'(FILT_LEN);
  localparam logic [5:0] c_TMR_LAST = 6'(TIMEOUT - 1);
  localparam logic [3:0] c_RES_LAST = 4'(RES_LEN - 1);

  nibble_t    buf_q [BUF_DEPTH];
  state_e     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [5:0] tmr_q, tmr_d;
  logic [3:0] ridx_q, ridx_d;
  logic       fv_q, fv_d, iv_q, iv_d;
  logic       done_q, done_d, err_q, err_d;
  nibble_t    data_q, data_d;
  logic       cap_en;
  logic [3:0] cap_addr;
  logic       buf_we;
  nibble_t    first_tap;
  result_t    rd_word;

  assign buf_we = (state_q == S_IDLE) && wr_en && (wr_addr < 7'(BUF_DEPTH));

  // A write to tap 0 in the start cycle must reach the first beat on the wire.
  assign first_tap = (buf_we && (wr_addr == 7'd0)) ? nibble_t'(wr_data) : buf_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (buf_we) begin
      buf_q[wr_addr] <= nibble_t'(wr_data);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    ridx_d   = ridx_q;
    fv_d     = 1'b0;
    iv_d     = 1'b0;
    data_d   = '0;
    done_d   = 1'b0;
    err_d    = err_q;
    cap_en   = 1'b0;
    cap_addr = ridx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND_FILT;
          idx_d   = '0;
          err_d   = 1'b0;
          fv_d    = 1'b1;
          data_d  = first_tap;
        end
      end
      S_SEND_FILT, S_SEND_IMG: begin
        if (idx_q == c_LAST_IDX) begin
          state_d = S_WAIT;
          tmr_d   = 6'd1;
        end else begin
          idx_d   = idx_q + 7'd1;
          data_d  = buf_q[idx_d];
          fv_d    = (idx_d < c_FILT_END);
          iv_d    = ~fv_d;
          state_d = fv_d ? S_SEND_FILT : S_SEND_IMG;
        end
      end
      S_WAIT: begin
        if (out_valid) begin
          cap_en   = 1'b1;
          cap_addr = 4'd0;
          ridx_d   = 4'd1;
          state_d  = S_COLLECT;
        end else if (tmr_q == c_TMR_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 6'd1;
        end
      end
      S_COLLECT: begin
        if (out_valid) begin
          cap_en = 1'b1;
          ridx_d = ridx_q + 4'd1;
          if (ridx_q == c_RES_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          // Engine stopped early: keep partial results, flag the frame.
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      ridx_q  <= '0;
      fv_q    <= 1'b0;
      iv_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      ridx_q  <= ridx_d;
      fv_q    <= fv_d;
      iv_q    <= iv_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  conv_result_buf u_result_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cap_en),
    .waddr_i (cap_addr),
    .wdata_i (result_t'(out_data)),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign filter_valid = fv_q;
  assign image_valid  = iv_q;
  assign in_data      = data_q;
  assign rd_data      = rd_word;

endmodule

`default_nettype wire

// File: tb/tb_conv_stream_driver.sv
//------------------------------------------------------------------------------
// tb_conv_stream_driver : self-checking bench for conv_stream_driver with a
//                         behavioural engine model and a beat scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_stream_driver;

  localparam int NBUF = 74;
  localparam int NRES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        start;
  logic        busy, done, err;
  logic        filter_valid, image_valid;
  logic [3:0]  in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  conv_stream_driver dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .filter_valid (filter_valid),
    .image_valid  (image_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       fv;
    logic       iv;
    logic [3:0] d;
  } beat_t;

  typedef struct {
    int          pat;
    int          nres;
    logic [15:0] rbase;
    logic [15:0] rstep;
    logic        exp_err;
  } vec_t;

  beat_t       exp_q[$];
  logic [3:0]  model_buf [NBUF];
  logic [15:0] exp_res   [NRES];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pat_val(input int pat, input int a);
    logic [3:0] v;
    case (pat)
      0:       v = 4'h1;
      1:       v = (a < 10) ? ((a == 0 || a == 5) ? 4'h1 : 4'h0) : 4'((a - 10) % 8);
      default: v = 4'h8;
    endcase
    return v;
  endfunction

  task automatic check_results(input string tag);
    for (int i = 0; i < NRES; i++) begin
      rd_addr = 4'(i);
      #1;
      chk({tag, "_rd_data"}, 32'(rd_data), 32'(exp_res[i]));
    end
  endtask

  task automatic run_frame(input int pat, input bit do_write, input int nres,
                           input logic [15:0] rbase, input logic [15:0] rstep,
                           input logic exp_err, input bit inj_busy, input int rst_at);
    int    last_iv_cyc, last_ov_cyc, exp_done_cyc, done_cyc;
    bit    aborted;
    beat_t e;
    aborted     = 1'b0;
    last_iv_cyc = 0;
    last_ov_cyc = 0;
    if (do_write) begin
      for (int a = 1; a < NBUF; a++) begin
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 7'(a); wr_data = pat_val(pat, a);
      end
    end
    @(negedge clk);
    wr_en   = do_write;
    wr_addr = 7'd0;
    wr_data = pat_val(pat, 0);
    start   = 1'b1;
    if (do_write)
      for (int a = 0; a < NBUF; a++) model_buf[a] = pat_val(pat, a);
    for (int k = 0; k < NBUF; k++)
      exp_q.push_back('{fv: (k < 10), iv: (k >= 10), d: model_buf[k]});
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    chk("err_cleared_by_start", 32'(err), 32'd0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int k = 0; k < NBUF; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_drops_valids", {28'd0, filter_valid, image_valid, busy, done}, 32'd0);
        chk("rst_in_data", 32'(in_data), 32'd0);
        exp_q.delete();
        for (int a = 0; a < NBUF; a++) model_buf[a] = 4'h0;
        for (int i = 0; i < NRES; i++) exp_res[i] = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      e = exp_q.pop_front();
      chk("beat", {29'd0, filter_valid, image_valid, 1'b0} | 32'(in_data) << 4,
          {29'd0, e.fv, e.iv, 1'b0} | 32'(e.d) << 4);
      if (k == NBUF - 1) last_iv_cyc = cyc;
      if (inj_busy && k == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 7'd20; wr_data = 4'hF;
      end else if (inj_busy && k == 6) begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    if (!aborted) begin
      chk("idle_after_stream", {25'd0, filter_valid, image_valid, in_data, busy},
          {25'd0, 1'b0, 1'b0, 4'h0, 1'b1});
      if (nres > 0) begin
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < nres; i++) begin
          out_valid  = 1'b1;
          out_data   = rbase + 16'(i) * rstep;
          exp_res[i] = out_data;
          last_ov_cyc = cyc;
          @(negedge clk);
        end
        out_valid = 1'b0;
        out_data  = 16'h0;
      end
      if (nres == 0)       exp_done_cyc = last_iv_cyc + 32;
      else if (nres == 16) exp_done_cyc = last_ov_cyc + 1;
      else                 exp_done_cyc = last_ov_cyc + 2;
      done_cyc = -1;
      for (int t = 0; t < 64; t++) begin
        if (done) begin
          done_cyc = cyc;
          break;
        end
        @(negedge clk);
      end
      chk("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
      chk("busy_low_at_done", 32'(busy), 32'd0);
      chk("err_at_done", 32'(err), 32'(exp_err));
      @(negedge clk);
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("err_sticky", 32'(err), 32'(exp_err));
    end
    check_results("frame");
  endtask

  vec_t vecs [5];

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    out_valid = 1'b0; out_data = '0; rd_addr = '0;
    for (int a = 0; a < NBUF; a++) model_buf[a] = 4'h0;
    for (int i = 0; i < NRES; i++) exp_res[i] = 16'h0;

    vecs[0] = '{pat: 0, nres: 16, rbase: 16'd25,   rstep: 16'd0,    exp_err: 1'b0};
    vecs[1] = '{pat: 1, nres: 16, rbase: 16'd100,  rstep: 16'd3,    exp_err: 1'b0};
    vecs[2] = '{pat: 2, nres: 16, rbase: 16'hF9C0, rstep: 16'd0,    exp_err: 1'b0};
    vecs[3] = '{pat: 1, nres: 0,  rbase: 16'h0,    rstep: 16'd0,    exp_err: 1'b1};
    vecs[4] = '{pat: 0, nres: 7,  rbase: 16'h8000, rstep: 16'h0011, exp_err: 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {26'd0, busy, done, err, filter_valid, image_valid, 1'b0} | 32'(in_data),
        32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {27'd0, busy, done, err, filter_valid, image_valid}, 32'd0);
    check_results("reset");

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].pat, 1'b1, vecs[v].nres, vecs[v].rbase, vecs[v].rstep,
                vecs[v].exp_err, 1'b0, -1);

    // start and wr_en while busy must not disturb this or the next frame
    run_frame(1, 1'b1, 16, 16'h0100, 16'h0001, 1'b0, 1'b1, -1);
    run_frame(1, 1'b0, 16, 16'h0200, 16'h0002, 1'b0, 1'b0, -1);

    // out_valid while idle leaves results untouched
    @(negedge clk);
    out_valid = 1'b1; out_data = 16'h1234;
    repeat (3) @(negedge clk);
    out_valid = 1'b0; out_data = 16'h0;
    chk("idle_out_valid_busy", 32'(busy), 32'd0);
    check_results("idle_ov");

    // reset in the middle of the image stream
    run_frame(2, 1'b1, 16, 16'h0, 16'h0, 1'b0, 1'b0, 40);
    repeat (3) @(negedge clk);
    chk("no_restart_after_rst", {29'd0, filter_valid, image_valid, busy}, 32'd0);

    run_frame(0, 1'b1, 16, 16'h0042, 16'h0005, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
